somador: RTL and testbench

- Registered binary adder: sums two unsigned operands `a` and `b`, producing sum `s` and carry-out `c`.
- With default WIDTH=1 it is a clocked half adder: s = a XOR b, c = a AND b.
- Used as a leaf arithmetic cell in the datapath.
- Result is captured in output registers, so downstream logic sees a stable, glitch-free value one cycle after the operands are presented.

---
 rtl/somador_if.sv | 30 +++
 rtl/somador.sv | 58 +++++
 tb/tb_somador.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/somador_if.sv
// Operand/result bundle for the somador registered adder.
// The producer of operands uses the master modport; the adder uses slave.
interface somador_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] s;
    logic             out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        input  c,
        input  s,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output c,
        output s,
        output out_valid
    );
endinterface

// File: rtl/somador.sv
// Registered unsigned adder built as a ripple chain of one-bit cells.
// Bit 0 is a half adder and the upper bits are full adders.
// Sum and carry are captured one clock after valid operands arrive.
// When the operands are not valid, the previous result is held.
module somador #(
    parameter int WIDTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    somador_if.slave bus
);

    // carry_chain[k] is the carry out of bit k-1.
    // carry_chain[WIDTH] is the final carry-out.
    logic [WIDTH:1]   carry_chain;
    logic [WIDTH-1:0] s_next;
    logic             c_next;

    logic [WIDTH-1:0] s_reg;
    logic             c_reg;
    logic             out_valid_reg;

    // Bit 0 has no incoming carry, so it is a plain half adder.
    assign s_next[0]      = bus.a[0] ^ bus.b[0];
    assign carry_chain[1] = bus.a[0] & bus.b[0];

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_full_adder
            assign s_next[gi]        = bus.a[gi] ^ bus.b[gi] ^ carry_chain[gi];
            assign carry_chain[gi+1] = (bus.a[gi] & bus.b[gi])
                                     | (carry_chain[gi] & (bus.a[gi] ^ bus.b[gi]));
        end
    endgenerate

    assign c_next = carry_chain[WIDTH];

    // Capture the result on valid operands; otherwise keep the last result
    // and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg         <= '0;
            c_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s_reg <= s_next;
                c_reg <= c_next;
            end
        end
    end

    assign bus.s         = s_reg;
    assign bus.c         = c_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_somador.sv
// Self-checking bench for somador at WIDTH=1 and WIDTH=4.
// It applies table vectors, runs hand-written reset and hold sequences,
// and checks randomized streams against an arithmetic reference model.
module tb_somador;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    somador_if #(.WIDTH(1)) bus1();
    somador_if #(.WIDTH(4)) bus4();

    somador #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    somador #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       exp_c;
        logic [3:0] exp_s;
    } vec_t;

    vec_t tt1 [4];
    vec_t tt4 [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " w1 c"}, 32'(bus1.c), 32'd0);
        check({name, " w1 s"}, 32'(bus1.s), 32'd0);
        check({name, " w1 ov"}, 32'(bus1.out_valid), 32'd0);
        check({name, " w4 c"}, 32'(bus4.c), 32'd0);
        check({name, " w4 s"}, 32'(bus4.s), 32'd0);
        check({name, " w4 ov"}, 32'(bus4.out_valid), 32'd0);
    endtask

    initial begin
        logic [4:0] model_q [$];
        logic [4:0] exp_sum;
        logic [4:0] held;
        logic       exp_ov;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rv;

        tt1[0] = '{4'd0, 4'd0, 1'b0, 4'd0};
        tt1[1] = '{4'd0, 4'd1, 1'b0, 4'd1};
        tt1[2] = '{4'd1, 4'd0, 1'b0, 4'd1};
        tt1[3] = '{4'd1, 4'd1, 1'b1, 4'd0};
        tt4[0] = '{4'hF, 4'h1, 1'b1, 4'h0};
        tt4[1] = '{4'hF, 4'hF, 1'b1, 4'hE};
        tt4[2] = '{4'h5, 4'h3, 1'b0, 4'h8};

        rst_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0;

        // Reset state, checked before any clock edge.
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table.
        for (int i = 0; i < 4; i++) begin
            bus1.a = tt1[i].a[0];
            bus1.b = tt1[i].b[0];
            bus1.in_valid = 1'b1;
            tick();
            check("tt1 c", 32'(bus1.c), 32'(tt1[i].exp_c));
            check("tt1 s", 32'(bus1.s), 32'(tt1[i].exp_s[0]));
            check("tt1 ov", 32'(bus1.out_valid), 32'd1);
            $display("w1 a=%0d b=%0d -> c=%0d s=%0d ov=%0d", tt1[i].a[0], tt1[i].b[0],
                     bus1.c, bus1.s, bus1.out_valid);
        end
        bus1.in_valid = 1'b0;
        $display("WIDTH=1 truth table complete");

        // WIDTH=4 wrap-around vectors.
        for (int i = 0; i < 3; i++) begin
            bus4.a = tt4[i].a;
            bus4.b = tt4[i].b;
            bus4.in_valid = 1'b1;
            tick();
            check("tt4 c", 32'(bus4.c), 32'(tt4[i].exp_c));
            check("tt4 s", 32'(bus4.s), 32'(tt4[i].exp_s));
            check("tt4 ov", 32'(bus4.out_valid), 32'd1);
            $display("w4 a=%h b=%h -> c=%0d s=%h ov=%0d", tt4[i].a, tt4[i].b,
                     bus4.c, bus4.s, bus4.out_valid);
        end
        bus4.in_valid = 1'b0;

        // Asynchronous reset mid-operation.
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.in_valid = 1'b1;
        bus4.a = 4'hF; bus4.b = 4'hF; bus4.in_valid = 1'b1;
        tick();
        check("pre-rst w1 c", 32'(bus1.c), 32'd1);
        check("pre-rst w1 s", 32'(bus1.s), 32'd0);
        check("pre-rst w1 ov", 32'(bus1.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        // Reset must win over a valid input at a clock edge.
        tick();
        check_all_zero("rst held");
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check_all_zero("post rst");
        $display("reset sequence complete");

        // Hold: in_valid low keeps s/c and clears out_valid.
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.in_valid = 1'b1;
        tick();
        check("hold load s", 32'(bus1.s), 32'd1);
        check("hold load c", 32'(bus1.c), 32'd0);
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus1.a = ~bus1.a;
            bus1.b = ~bus1.b;
            tick();
            check("hold s", 32'(bus1.s), 32'd1);
            check("hold c", 32'(bus1.c), 32'd0);
            check("hold ov", 32'(bus1.out_valid), 32'd0);
            $display("hold cycle %0d: c=%0d s=%0d ov=%0d", i, bus1.c, bus1.s, bus1.out_valid);
        end

        // Back-to-back random stream at WIDTH=4.
        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            bus4.a = ra; bus4.b = rb; bus4.in_valid = 1'b1;
            model_q.push_back(5'(int'(ra) + int'(rb)));
            tick();
            exp_sum = model_q.pop_front();
            check("b2b sum", 32'({bus4.c, bus4.s}), 32'(exp_sum));
            check("b2b ov", 32'(bus4.out_valid), 32'd1);
            $display("b2b %0d: a=%h b=%h -> {c,s}=%h", i, ra, rb, {bus4.c, bus4.s});
        end

        // Random valid/idle mix at WIDTH=4; the model remembers the last result.
        held = 5'(int'(ra) + int'(rb));
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rv = 1'($urandom_range(0, 1));
            bus4.a = ra; bus4.b = rb; bus4.in_valid = rv;
            if (rv) held = 5'(int'(ra) + int'(rb));
            exp_ov = rv;
            tick();
            check("mix sum", 32'({bus4.c, bus4.s}), 32'(held));
            check("mix ov", 32'(bus4.out_valid), 32'(exp_ov));
            $display("mix %0d: v=%0d a=%h b=%h -> {c,s}=%h ov=%0d", i, rv, ra, rb,
                     {bus4.c, bus4.s}, bus4.out_valid);
        end
        bus4.in_valid = 1'b0;

        // Random WIDTH=1 stream against the half-adder rule.
        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 1));
            rb = 4'($urandom_range(0, 1));
            bus1.a = ra[0]; bus1.b = rb[0]; bus1.in_valid = 1'b1;
            tick();
            check("w1 rand", 32'({bus1.c, bus1.s}), 32'(int'(ra) + int'(rb)));
            $display("w1 rand %0d: a=%0d b=%0d -> {c,s}=%0d", i, ra[0], rb[0], {bus1.c, bus1.s});
        end
        bus1.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
